// File: rtl/risc_pkg.sv
// Shared definitions for the LM/SM register-list sequencer: opcodes, FSM states, op kind.
package risc_pkg;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    localparam int unsigned REG_IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_LM   = 2'd1,
        KIND_SM   = 2'd2
    } kind_e;

endpackage

// File: rtl/lmsm_prio_enc.sv
// MSB-first priority encoder over the 8-bit register mask (bit 7 -> R0, bit 0 -> R7).
module lmsm_prio_enc
    import risc_pkg::*;
(
    input  logic [7:0]           mask,
    output logic [REG_IDX_W-1:0] idx,
    output logic                 any,
    output logic                 onehot
);

    always_comb begin
        idx = '0;
        // Ascending scan so the most significant set bit wins.
        for (int unsigned i = 0; i < 8; i++) begin
            if (mask[i]) begin
                idx = REG_IDX_W'(7 - i);
            end
        end
        any    = |mask;
        onehot = any && ((mask & (mask - 8'd1)) == 8'd0);
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: latches register mask and base address, then steps one transfer per SH_EN.
module lmsm_sequencer
    import risc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MASK_W    = 8,
    parameter int unsigned ADDR_STEP = 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 LOAD,
    input  logic [15:0]          IR_IN,
    input  logic [ADDR_W-1:0]    BASE_ADDR,
    input  logic                 SH_EN,
    input  logic                 FLUSH,
    output logic                 BUSY,
    output logic                 VALID,
    output logic [REG_IDX_W-1:0] REG_IDX,
    output logic [ADDR_W-1:0]    MEM_ADDR,
    output logic                 IS_LM,
    output logic                 IS_SM,
    output logic                 IS_IMM_ZERO_LM,
    output logic                 IS_IMM_ZERO_SM,
    output logic                 LAST,
    output logic [3:0]           XFER_CNT,
    output logic                 DONE
);

    state_e              state_q, state_d;
    kind_e               kind_q, kind_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          cnt_q, cnt_d;

    logic [REG_IDX_W-1:0] cur_idx;
    logic                 cur_any;
    logic                 cur_onehot;
    logic [3:0]           opcode;
    logic                 is_lmsm_op;
    logic                 unused_ir_bits;

    assign opcode         = IR_IN[15:12];
    assign is_lmsm_op     = (opcode == OP_LM) || (opcode == OP_SM);
    assign unused_ir_bits = ^IR_IN[11:8];

    lmsm_prio_enc u_prio_enc (
        .mask   (mask_q[7:0]),
        .idx    (cur_idx),
        .any    (cur_any),
        .onehot (cur_onehot)
    );

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;

        if (FLUSH) begin
            state_d = ST_IDLE;
            mask_d  = '0;
            kind_d  = KIND_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (LOAD && is_lmsm_op) begin
                        mask_d  = IR_IN[MASK_W-1:0];
                        addr_d  = BASE_ADDR;
                        cnt_d   = '0;
                        kind_d  = (opcode == OP_LM) ? KIND_LM : KIND_SM;
                        state_d = (IR_IN[MASK_W-1:0] != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (SH_EN) begin
                        // Bit position is the mirror of the register index.
                        mask_d  = mask_q & ~(MASK_W'(1) << (3'd7 - cur_idx));
                        addr_d  = addr_q + ADDR_W'(ADDR_STEP);
                        cnt_d   = (cnt_q == 4'd8) ? 4'd8 : cnt_q + 4'd1;
                        if (cur_onehot) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            kind_q  <= KIND_NONE;
            mask_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    logic in_run;
    logic in_done;

    always_comb begin
        in_run         = (state_q == ST_RUN);
        in_done        = (state_q == ST_DONE);
        BUSY           = (state_q != ST_IDLE);
        VALID          = in_run && cur_any;
        REG_IDX        = VALID ? cur_idx : '0;
        MEM_ADDR       = VALID ? addr_q : '0;
        LAST           = VALID && cur_onehot;
        IS_LM          = (in_run || in_done) && (kind_q == KIND_LM);
        IS_SM          = (in_run || in_done) && (kind_q == KIND_SM);
        IS_IMM_ZERO_LM = (kind_q == KIND_LM) && (LAST || in_done);
        IS_IMM_ZERO_SM = (kind_q == KIND_SM) && (LAST || in_done);
        XFER_CNT       = cnt_q;
        DONE           = in_done;
    end

endmodule
